// File: rtl/video_stream_tx_pkg.sv
// Shared definitions for the video stream transmitter: pixel/word sizes,
// FSM state encodings and the default memory address width.
package video_stream_tx_pkg;

  localparam int PIXEL_SIZE = 8;
  localparam int WORD_SIZE  = 32;

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_RUN  = 1'b1;

  localparam int TX_ADDR_W = 19;

endpackage

// File: rtl/video_stream_tx_raster_counter.sv
// raster_counter: x/y raster position with wrap, plus active/hblank/vblank
// flags and the frame-end marker for the current position.
module raster_counter
  import video_stream_tx_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic step,
  output logic active,
  output logic hblank,
  output logic vblank,
  output logic frame_end
);

  localparam int XN = WIDTH + H_BLANK;
  localparam int YN = HEIGHT + V_BLANK;
  localparam int XW = $clog2(XN);
  localparam int YW = $clog2(YN);
  localparam logic [XW-1:0] X_LAST = XW'(XN - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(WIDTH);
  localparam logic [YW-1:0] Y_LAST = YW'(YN - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(HEIGHT);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign hblank    = (x_q >= X_ACT);
  assign vblank    = (y_q >= Y_ACT);
  assign active    = !hblank && !vblank;
  assign frame_end = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/video_stream_tx.sv
// Frame-buffer reader and raster timing generator feeding the edge detector.
// Optional macro VIDEO_STREAM_TX_CONTINUOUS_EN: back-to-back frames while start is held.
module video_stream_tx
  import video_stream_tx_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 4,
  parameter int ADDR_W  = TX_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_data,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data
);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d, hsync_q, hsync_d, vsync_q, vsync_d, done_q, done_d;
  logic              run, cnt_clear, cnt_step;
  logic              active, hblank, vblank, frame_end;

  assign run = (state_q == TX_RUN);

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .H_BLANK(H_BLANK),
    .V_BLANK(V_BLANK)
  ) u_raster (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .step     (cnt_step),
    .active   (active),
    .hblank   (hblank),
    .vblank   (vblank),
    .frame_end(frame_end)
  );

  // Stage 1: counter cycle drives the read; flags are captured for stage 2
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    en_d      = 1'b0;
    hsync_d   = 1'b0;
    vsync_d   = 1'b0;
    done_d    = 1'b0;
    if (run) begin
      cnt_step = 1'b1;
      en_d     = active;
      hsync_d  = hblank;
      vsync_d  = vblank;
      if (active) addr_d = addr_q + 1'b1;
      if (frame_end) begin
        addr_d = '0;
        done_d = 1'b1;
`ifdef VIDEO_STREAM_TX_CONTINUOUS_EN
        if (!start) state_d = TX_IDLE;
`else
        state_d = TX_IDLE;
`endif
      end
    end else if (start) begin
      state_d   = TX_RUN;
      cnt_clear = 1'b1;
    end
  end

  // Stage 2: output register aligned with the memory's read latency
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      done_q  <= done_d;
    end
  end

  assign busy     = run;
  assign mem_rd   = run && active;
  assign mem_addr = addr_q;
  assign en       = en_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign done     = done_q;
  assign data     = en_q ? mem_data : '0;

endmodule
